fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//   Instruction-fetch stage between the PC register and decode. Samples the
//   PC value, captures the instruction returned one cycle later by the
//   synchronous-read instruction memory, and buffers {pc, instr} pairs in a
//   DEPTH-entry FIFO drained by decode through a valid/ready handshake.
//   It back-pressures the PC through pc_stall, which drives the PC register_write input.
//   The PC updates when register_write=0.
// PARAMETERS
//   DEPTH   4   FIFO entries; power of 2, >= 2
//   PC_W    32  PC width
//   INSTR_W 32  instruction width
// PORTS
//   clk        in   1        clock, all state on posedge
//   rst        in   1        asynchronous, active-high reset
//   pc_in      in   PC_W     current PC value (address presented to imem)
//   imem_rdata in   INSTR_W  imem data for address sampled on previous edge
//   flush      in   1        redirect (branch/jump): discard all fetched state
//   id_ready   in   1        decode accepts head entry this cycle
//   pc_stall   out  1        1 = PC must hold (to PC register_write)
//   id_valid   out  1        head entry valid
//   id_pc      out  PC_W     PC of head entry
//   id_instr   out  INSTR_W  instruction of head entry
//   count      out  clog2(DEPTH)+1  entries currently held
// BEHAVIOUR
// - Reset (async, immediate): count=0, rd/wr ptr=0, fetch_pending=0, pc_q=0.
//   Outputs: id_valid=0, id_pc=0, id_instr=0, pc_stall=0.
// - Issue: on an edge with pc_stall=0, flush=0 -> fetch_pending<=1, pc_q<=pc_in.
//   Otherwise fetch_pending<=0.
// - Capture: on an edge with fetch_pending=1, flush=0 -> write {pc_q, imem_rdata} at wr_ptr.
//   Then wr_ptr+1 modulo DEPTH.
// - Latency: pc_in sampled at edge n -> entry visible (id_valid=1) after edge n+1.
// - pc_stall = !flush && (count + fetch_pending >= DEPTH). Purely registered terms.
//   A same-cycle pop is NOT credited (conservative). Overflow is impossible by construction.
// - id_valid = (count != 0). id_pc/id_instr = head entry when valid, else 0.
// - Pop: id_valid && id_ready at an edge -> rd_ptr+1 modulo DEPTH.
//   Head data stays stable while id_valid && !id_ready.
// - Count: write only +1; pop only -1; simultaneous write+pop unchanged (legal at full).
//   id_ready with count=0 is ignored.
// - Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. Count disambiguates full/empty.
// - Flush (synchronous, overrides everything): count<=0, rd_ptr<=wr_ptr<=0, fetch_pending<=0.
//   The in-flight fetch and any same-cycle pop are discarded.
//   pc_stall forced 0 so the PC loads the redirect target.
//   No fetch is issued in the flush cycle; the first fetch of the target occurs on the next edge.
// - Reset asserted mid-operation: all state clears at once with no edge required.
//   After rst falls, the first issue occurs on the next edge with pc_stall=0.
// TESTING
// 1 Reset: assert rst between edges -> id_valid=0, count=0, pc_stall=0 immediately.
// 2 Stream: id_ready=1, pc_in 0x00,0x04,0x08 on consecutive edges, imem_rdata A0,A4,A8 one cycle later
//   -> id_pc/id_instr 0x00/A0, 0x04/A4, 0x08/A8 in order; first id_valid one edge after its issue.
// 3 Fill: id_ready=0, DEPTH=4, continuous issue -> pc_stall=1 once count+pending=4; count saturates at 4.
//   Entries 0x00..0x0C intact; no 5th write.
// 4 Full push+pop: count=3, pending=1, id_ready=1 -> count stays 3 then drains in order.
//   Each pop frees a slot; next issue proceeds.
// 5 Flush: count=3, pending=1, flush=1 for one edge -> count=0, id_valid=0, pc_stall=0.
//   The pending entry never appears; the next issue uses the new pc_in.
// 6 Wrap: issue 10 entries with id_ready toggling 1/0 -> pointers wrap twice.
//   Output order and data match the issue sequence exactly.

Source files
------------

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction-fetch stage that pairs each issued PC with the
//            synchronous imem response and queues {pc, instr} for decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PC_W-1:0]          pc_in,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     flush,
  input  logic                     id_ready,
  output logic                     pc_stall,
  output logic                     id_valid,
  output logic [PC_W-1:0]          id_pc,
  output logic [INSTR_W-1:0]       id_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             fetch_pending_q, fetch_pending_d;
  logic [PC_W-1:0]  pc_q, pc_d;

  logic [CNT_W:0]   occupancy;
  logic             do_issue;
  logic             do_capture;
  logic             do_pop;

  // Occupancy counts the in-flight fetch so a slot is always reserved for it;
  // a same-cycle pop is deliberately not credited.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, fetch_pending_q};
    pc_stall   = !flush && (occupancy >= DEPTH_EXT);
    do_issue   = !pc_stall && !flush;
    do_capture = fetch_pending_q && !flush;
    do_pop     = (count_q != '0) && id_ready && !flush;
  end

  always_comb begin
    count_d         = count_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    fetch_pending_d = do_issue;
    pc_d            = pc_q;

    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (do_issue) begin
        pc_d = pc_in;
      end
      if (do_capture) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_capture, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q         <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      fetch_pending_q <= 1'b0;
      pc_q            <= '0;
    end else begin
      count_q         <= count_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      fetch_pending_q <= fetch_pending_d;
      pc_q            <= pc_d;
    end
  end

  // Storage needs no reset: nothing is visible until count marks it valid.
  always_ff @(posedge clk) begin
    if (do_capture) begin
      pc_mem[wr_ptr_q]    <= pc_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  always_comb begin
    id_valid = (count_q != '0);
    id_pc    = id_valid ? pc_mem[rd_ptr_q]    : '0;
    id_instr = id_valid ? instr_mem[rd_ptr_q] : '0;
    count    = count_q;
  end

endmodule
`default_nettype wire
